// File: rtl/axis_burst_reader_pkg.sv
// axis_burst_reader_pkg: shared FSM state encoding and default flush timeout
package axis_burst_reader_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_e;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/axis_burst_reader_obuf.sv
// axis_burst_reader_obuf: one-deep registered AXI-Stream output stage carrying data, valid and last
module axis_burst_reader_obuf
    import axis_burst_reader_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         last,
    input  logic         ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    output logic         m_last
);
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_data  <= data;
            m_valid <= 1'b1;
            m_last  <= last;
        end else if (ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end
endmodule

// File: rtl/axis_burst_reader.sv
// axis_burst_reader: frames FIFO words into N-beat AXI-Stream bursts; AXIS_BURST_READER_FLUSH_EN adds a partial-burst flush timer
module axis_burst_reader
    import axis_burst_reader_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES   = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [CNTR_WIDTH-1:0]       cfg_data,
    input  logic [31:0]                 fifo_count,
    output logic [31:0]                 sts_data,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast
);
    state_e                state;
    logic [CNTR_WIDTH-1:0] rem;
    logic [CNTR_WIDTH-1:0] start_len;
    logic                  start;
    logic                  s_fire;
    logic                  last_word;
    logic                  full_ready;

    assign s_axis_tready = (state == BURST) && (rem != '0) && (!m_axis_tvalid || m_axis_tready);
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign last_word     = rem == CNTR_WIDTH'(1);
    assign full_ready    = (cfg_data != '0) && (fifo_count >= 32'(cfg_data));

`ifdef AXIS_BURST_READER_FLUSH_EN
    logic [31:0] idle_cnt;
    logic        partial;
    logic        flush;
    assign partial   = (fifo_count != '0) && (fifo_count < 32'(cfg_data));
    assign flush     = partial && (idle_cnt >= 32'(TIMEOUT_CYCLES - 1));
    assign start     = (state == IDLE) && (full_ready || flush);
    assign start_len = full_ready ? cfg_data : fifo_count[CNTR_WIDTH-1:0];
    always_ff @(posedge aclk) begin
        if (areset || state != IDLE || start || !partial)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 32'd1;
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign start     = (state == IDLE) && full_ready;
    assign start_len = cfg_data;
`endif

    // length is captured only on IDLE->BURST so cfg_data edits mid-burst are ignored
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
            rem   <= '0;
        end else if (start) begin
            state <= BURST;
            rem   <= start_len;
        end else if (s_fire) begin
            rem   <= rem - CNTR_WIDTH'(1);
            state <= last_word ? IDLE : BURST;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset)
            sts_data <= '0;
        else if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
            sts_data <= sts_data + 32'd1;
    end

    axis_burst_reader_obuf #(.W(AXIS_TDATA_WIDTH)) u_obuf (
        .aclk    (aclk),
        .areset  (areset),
        .load    (s_fire),
        .data    (s_axis_tdata),
        .last    (last_word),
        .ready   (m_axis_tready),
        .m_data  (m_axis_tdata),
        .m_valid (m_axis_tvalid),
        .m_last  (m_axis_tlast)
    );
endmodule

// File: tb/tb_axis_burst_reader.sv
// tb_axis_burst_reader: directed self-checking bench for axis_burst_reader
module tb_axis_burst_reader;
    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] cfg_data;
    logic [31:0] fifo_count;
    logic [31:0] sts_data;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int avail = 0;
    int next_word = 1;
    int exp_sts = 0;
    int first_rdy = -1;
    logic sv_en = 1'b1;
    logic tog = 1'b0;
    logic hold = 1'b0;
    logic [31:0] hold_d;
    logic rdy_seen, vld_seen;
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          got_t[$];

    always #5 aclk = ~aclk;

    axis_burst_reader #(
        .AXIS_TDATA_WIDTH(32),
        .CNTR_WIDTH(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_data      (cfg_data),
        .fifo_count    (fifo_count),
        .sts_data      (sts_data),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock period: entered and left on a falling edge; handshakes are sampled just before the rising edge
    task automatic tick();
        if (hold) begin
            chk("hold_valid", {31'b0, m_axis_tvalid}, 32'd1);
            chk("hold_data", m_axis_tdata, hold_d);
        end
        if (tog) m_axis_tready = !m_axis_tready;
        fifo_count    = avail;
        s_axis_tdata  = next_word;
        s_axis_tvalid = (avail != 0) && sv_en;
        #1;
        if (m_axis_tvalid && m_axis_tready) begin
            got_d.push_back(m_axis_tdata);
            got_l.push_back(m_axis_tlast);
            got_t.push_back(cyc);
        end
        hold   = m_axis_tvalid && !m_axis_tready;
        hold_d = m_axis_tdata;
        if (s_axis_tready) rdy_seen = 1'b1;
        if (m_axis_tvalid) vld_seen = 1'b1;
        if (s_axis_tready && first_rdy < 0) first_rdy = cyc;
        if (s_axis_tvalid && s_axis_tready) begin
            next_word++;
            avail--;
        end
        @(negedge aclk);
        cyc++;
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int b = budget;
        while (got_d.size() < n && b > 0) begin
            tick();
            b--;
        end
        chk({tag, "_beats"}, got_d.size(), n);
    endtask

    task automatic chk_burst(input string tag, input int base, input int n, input logic [31:0] first);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_d[base+i], first + i);
            chk($sformatf("%s_last%0d", tag, i), {31'b0, got_l[base+i]}, (i == n - 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        got_t.delete();
    endtask

    initial begin
        int w0;
        int c0;
        int b;
        areset = 1'b1;
        cfg_data = '0;
        fifo_count = '0;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        chk("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        chk("rst_tlast", {31'b0, m_axis_tlast}, 32'd0);
        chk("rst_tdata", m_axis_tdata, 32'd0);
        chk("rst_sts", sts_data, 32'd0);
        chk("rst_tready", {31'b0, s_axis_tready}, 32'd0);
        areset = 1'b0;

        // basic 4-beat burst, back-to-back output
        cfg_data = 16'd4;
        avail = 4;
        w0 = next_word;
        run_until("a", 4, 30);
        chk_burst("a", 0, 4, w0);
        for (int i = 1; i < 4; i++) chk($sformatf("a_gap%0d", i), got_t[i] - got_t[0], i);
        exp_sts++;
        chk("a_sts", sts_data, exp_sts);
        chk("a_idle_tvalid", {31'b0, m_axis_tvalid}, 32'd0);

        // partial FIFO: stuck without the flush timer, flushed after 16 idle cycles with it
        clear_log();
        avail = 3;
        rdy_seen = 1'b0;
        vld_seen = 1'b0;
        first_rdy = -1;
        c0 = cyc;
        w0 = next_word;
`ifdef AXIS_BURST_READER_FLUSH_EN
        run_until("flush", 3, 100);
        chk("flush_start", first_rdy - c0, 16);
        chk_burst("flush", 0, 3, w0);
        exp_sts++;
        chk("flush_sts", sts_data, exp_sts);
`else
        for (int i = 0; i < 5000; i++) tick();
        chk("stuck_tready", {31'b0, rdy_seen}, 32'd0);
        chk("stuck_tvalid", {31'b0, vld_seen}, 32'd0);
        chk("stuck_words", avail, 3);
        chk("stuck_sts", sts_data, exp_sts);
        avail = 0;
`endif

        // 8-beat burst with m_axis_tready toggling and a 3-cycle source gap
        clear_log();
        cfg_data = 16'd8;
        avail = 8;
        w0 = next_word;
        tog = 1'b1;
        b = 60;
        while (next_word != w0 + 3 && b > 0) begin
            tick();
            b--;
        end
        sv_en = 1'b0;
        repeat (3) tick();
        sv_en = 1'b1;
        run_until("c", 8, 100);
        chk_burst("c", 0, 8, w0);
        tog = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) tick();
        exp_sts++;
        chk("c_sts", sts_data, exp_sts);

        // cfg_data changes mid-burst only affect the following burst
        clear_log();
        cfg_data = 16'd4;
        avail = 6;
        w0 = next_word;
        b = 30;
        while (next_word == w0 && b > 0) begin
            tick();
            b--;
        end
        cfg_data = 16'd2;
        run_until("d", 6, 60);
        chk_burst("d1", 0, 4, w0);
        chk_burst("d2", 4, 2, w0 + 4);
        exp_sts += 2;
        chk("d_sts", sts_data, exp_sts);

        // reset mid-burst abandons it; the next burst is framed from scratch
        clear_log();
        cfg_data = 16'd4;
        avail = 4;
        run_until("e_pre", 2, 30);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk("e_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        chk("e_tlast", {31'b0, m_axis_tlast}, 32'd0);
        chk("e_tdata", m_axis_tdata, 32'd0);
        chk("e_sts", sts_data, 32'd0);
        chk("e_tready", {31'b0, s_axis_tready}, 32'd0);
        for (int i = 0; i < got_l.size(); i++) chk($sformatf("e_nolast%0d", i), {31'b0, got_l[i]}, 32'd0);
        clear_log();
        avail = 4;
        w0 = next_word;
        run_until("e", 4, 30);
        chk_burst("e", 0, 4, w0);
        chk("e_sts_after", sts_data, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
